// File: rtl/simon_sequence_player.sv
// simon_sequence_player
//
// Plays a Simon Says colour sequence on four one-hot LEDs. Each step takes two
// divider ticks: one tick lights the LED and the next tick darkens it. Every
// accepted start reloads a 16-bit Fibonacci LFSR from the stored seed. Each round
// therefore replays the same prefix and then plays the requested number of steps.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   tick_i       single-cycle pulse from the clock divider
//   start_i      begin playback (sampled only in idle)
//   length_i     steps to play, clamped to MAX_LEN, latched on accepted start
//   seed_load_i  load seed_i into the seed register (idle only)
//   seed_i       new seed; zero is replaced by LFSR_SEED
//   led_o        one-hot colour display, registered
//   busy_o       high while waiting for the first tick or playing
//   done_o       one-cycle pulse at the end of playback
module simon_sequence_player #(
    parameter int unsigned MAX_LEN   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_i,
    input  logic        start_i,
    input  logic [4:0]  length_i,
    input  logic        seed_load_i,
    input  logic [15:0] seed_i,
    output logic [3:0]  led_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [4:0] MaxLen = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        StIdle,
        StWaitSync,
        StShow,
        StGap,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  led_q, led_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [4:0]  count_q, count_d;
    logic [4:0]  len_q, len_d;
    logic [15:0] seed_q, seed_d;
    logic [15:0] lfsr_q, lfsr_d;

    logic [15:0] seed_eff;
    logic [4:0]  len_clamped;
    logic        lfsr_fb;
    logic [15:0] lfsr_next;
    logic [3:0]  led_color;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            led_q   <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= 5'd0;
            len_q   <= 5'd0;
            seed_q  <= LFSR_SEED;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            len_q   <= len_d;
            seed_q  <= seed_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_comb begin
        // An all-zero seed would lock the LFSR, so substitute the default.
        seed_eff    = (seed_i == 16'h0000) ? LFSR_SEED : seed_i;
        len_clamped = (length_i > MaxLen) ? MaxLen : length_i;
        lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_next   = {lfsr_q[14:0], lfsr_fb};
        led_color   = 4'(4'b0001 << lfsr_q[1:0]);

        state_d = state_q;
        led_d   = led_q;
        count_d = count_q;
        len_d   = len_q;
        seed_d  = seed_q;
        lfsr_d  = lfsr_q;

        case (state_q)
            StIdle: begin
                if (seed_load_i) begin
                    seed_d = seed_eff;
                end
                if (start_i) begin
                    // A coincident seed_load already applies to this round.
                    lfsr_d  = seed_load_i ? seed_eff : seed_q;
                    count_d = 5'd0;
                    len_d   = len_clamped;
                    state_d = (len_clamped == 5'd0) ? StDone : StWaitSync;
                end
            end
            StWaitSync: begin
                if (tick_i) begin
                    led_d   = led_color;
                    state_d = StShow;
                end
            end
            StShow: begin
                if (tick_i) begin
                    led_d   = 4'b0000;
                    lfsr_d  = lfsr_next;
                    count_d = count_q + 5'd1;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (tick_i) begin
                    if (count_q == len_q) begin
                        state_d = StDone;
                    end else begin
                        led_d   = led_color;
                        state_d = StShow;
                    end
                end
            end
            StDone: begin
                led_d   = 4'b0000;
                state_d = StIdle;
            end
            default: begin
                led_d   = 4'b0000;
                state_d = StIdle;
            end
        endcase

        // busy and done come from the next state so that they stay registered
        // and line up with the state register.
        busy_d = (state_d == StWaitSync) || (state_d == StShow) || (state_d == StGap);
        done_d = (state_d == StDone);
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_simon_sequence_player.sv
// Bench for simon_sequence_player. Stimulus tasks push the expected LED and done
// events, together with the cycle in which each event should appear, into a
// queue. A monitor on the falling edge pops and compares an entry whenever the
// LED value changes or done is high.
module tb_simon_sequence_player;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  length = 5'd0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic [3:0]  led;
    logic        busy;
    logic        done;

    simon_sequence_player #(
        .MAX_LEN   (16),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_i      (tick),
        .start_i     (start),
        .length_i    (length),
        .seed_load_i (seed_load),
        .seed_i      (seed),
        .led_o       (led),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0]  led;
        logic        busy;
        logic        done;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] c);
        logic [3:0] r;
        r = 4'b0000;
        r[c] = 1'b1;
        return r;
    endfunction

    // Monitor: every LED change or done pulse must match the next expected event.
    logic [3:0] led_prev = 4'b0000;
    always @(negedge clk) begin
        if (reset === 1'b0 && (led !== led_prev || done === 1'b1)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: led=%b busy=%b done=%b at cycle %0d, none expected",
                         led, busy, done, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ev_led", 32'(led), 32'(e.led));
                check("ev_busy", 32'(busy), 32'(e.busy));
                check("ev_done", 32'(done), 32'(e.done));
                check("ev_cycle", cyc, e.cyc);
            end
        end
        led_prev = led;
    end

    task automatic expect_ev(input logic [3:0] l, input logic b, input logic d, input int dly);
        exp_t e;
        e.led  = l;
        e.busy = b;
        e.done = d;
        e.cyc  = cyc + 32'(dly);
        exp_q.push_back(e);
    endtask

    // One tick pulse. Its effect is expected in the cycle after the sampling edge.
    task automatic step(input logic [3:0] l, input logic b, input logic d);
        @(negedge clk);
        tick = 1'b1;
        expect_ev(l, b, d, 1);
        @(negedge clk);
        tick = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic start_run(input logic [4:0] len, input logic ld, input logic [15:0] sd,
                             input logic with_tick);
        @(negedge clk);
        start     = 1'b1;
        length    = len;
        seed_load = ld;
        seed      = sd;
        tick      = with_tick;
        if (len == 5'd0) expect_ev(4'b0000, 1'b0, 1'b1, 1);
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
        tick      = 1'b0;
        check("busy_after_start", 32'(busy), 32'(len != 5'd0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [15:0] m;

        // Asynchronous reset before any clock edge.
        #1;
        check("reset_led", 32'(led), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Length 2 with the default seed: ACE1 -> colour 1, 59C3 -> colour 3.
        start_run(5'd2, 1'b0, 16'h0000, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        check("busy_after_done", 32'(busy), 32'h0);

        // Loading a zero seed substitutes ACE1.
        @(negedge clk);
        seed_load = 1'b1;
        seed      = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        start_run(5'd1, 1'b0, 16'h0000, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1);

        // Length 0 with start held for three edges. The first start is accepted,
        // the start seen in the done cycle is ignored, and the start in the next
        // idle cycle is accepted again.
        @(negedge clk);
        start  = 1'b1;
        length = 5'd0;
        expect_ev(4'b0000, 1'b0, 1'b1, 1);
        expect_ev(4'b0000, 1'b0, 1'b1, 3);
        repeat (2) @(negedge clk);
        check("len0_busy", 32'(busy), 32'h0);
        @(negedge clk);
        start = 1'b0;
        check("len0_led", 32'(led), 32'h0);
        repeat (3) @(negedge clk);

        // Length 31 clamps to 16 lit steps, and done follows tick 33.
        start_run(5'd31, 1'b0, 16'h0000, 1'b0);
        m = 16'hACE1;
        for (int i = 0; i < 16; i++) begin
            step(onehot(m[1:0]), 1'b1, 1'b0);
            step(4'b0000, 1'b1, 1'b0);
            m = lfsr_step(m);
        end
        step(4'b0000, 1'b0, 1'b1);

        // A tick coincident with start is ignored. A start or seed_load issued
        // while busy is also ignored.
        start_run(5'd1, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        start     = 1'b1;
        length    = 5'd5;
        seed_load = 1'b1;
        seed      = 16'h1234;
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
        check("busy_wait_sync", 32'(busy), 32'h1);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        start  = 1'b1;
        length = 5'd3;
        @(negedge clk);
        start = 1'b0;
        step(4'b0000, 1'b0, 1'b1);
        start_run(5'd1, 1'b0, 16'h0000, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1);

        // seed_load together with start: seed 0002 gives colour 2, then 0004 gives colour 0.
        start_run(5'd2, 1'b1, 16'h0002, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1);

        // Reset during SHOW clears the outputs without a clock edge and also
        // restores the default seed.
        start_run(5'd2, 1'b0, 16'h0000, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_led", 32'(led), 32'h0);
        check("async_reset_busy", 32'(busy), 32'h0);
        check("async_reset_done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        start_run(5'd1, 1'b0, 16'h0000, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1);

        repeat (20) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/simon_sequence_player.md
# simon_sequence_player

Consumer end of the one-second tick stream: plays a Simon Says color sequence on the four game LEDs, one step per tick pair (on-tick, off-tick).
- Sequence is generated by a 16-bit LFSR reloaded from a stored seed at every start, so each round replays the same prefix and extends it by the requested length.
- Sits between the clock divider's single-cycle tick and the LED drivers.
- Game control issues start/length and waits for done.

## Interface
Parameters:
- MAX_LEN, 16: longest playable sequence (1..31); larger length requests clamp to this.
- LFSR_SEED, 16'hACE1: seed after reset, and replacement for an all-zero seed.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high.
- tick, input, 1: one-cycle pulse from the divider (one per second).
- start, input, 1: begin playback; sampled only in IDLE.
- length, input, 5: number of steps to play; latched on accepted start.
- seed_load, input, 1: load seed into seed register; honored only in IDLE.
- seed, input, 16: new seed value.
- led, output, 4: one-hot color display (bit n = color n), registered.
- busy, output, 1: high in WAIT_SYNC, SHOW and GAP.
- done, output, 1: one-cycle pulse at end of playback.

## Operation
- Reset (async) values:
  - state=IDLE, led=0, busy=0, done=0.
  - count=0, len=0.
  - seed_reg=LFSR_SEED, lfsr=LFSR_SEED.
- LFSR: Fibonacci, shift left.
  - fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]; next = {lfsr[14:0], fb}.
  - Current color = lfsr[1:0].
- seed_load in IDLE: seed_reg <= (seed==0) ? LFSR_SEED : seed. Ignored outside IDLE.
- States:
  - IDLE: on start, lfsr <= seed_reg, count <= 0, len <= min(length, MAX_LEN).
    - If the clamped length is 0, go to DONE.
    - Otherwise go to WAIT_SYNC.
    - start and seed_load in the same cycle: seed_load takes effect for this start (lfsr loads the new seed value, zero-substituted).
  - WAIT_SYNC: on tick, led <= onehot(lfsr[1:0]), go to SHOW. Aligns the first step to a full tick period.
  - SHOW: on tick, led <= 0, lfsr <= next, count <= count+1, go to GAP.
  - GAP: on tick:
    - If count==len, go to DONE.
    - Otherwise led <= onehot(lfsr[1:0]), go to SHOW.
  - DONE: done=1 for exactly this cycle, busy=0, led=0; next state IDLE unconditionally.
- Restrictions:
  - start is ignored while busy or in DONE.
  - No abort input; only reset ends playback early.
- count and len are 5 bits. Clamping guarantees count never exceeds len, so count never wraps.

## Timing
- All outputs are registered and change on the clk edge that samples the qualifying input.
- Start accepted at edge E0 → busy=1 after E0.
- A tick sampled in the same cycle as an accepted start is ignored; the first LED lights on the next tick after E0.
- Each step: LED lit for exactly one tick period, dark for one tick period.
- Length N≥1 needs 2N+1 ticks after start:
  - Tick 1 lights step 1.
  - Tick 2N+1 moves the FSM to DONE; done is high the cycle after that edge.
- Length 0 → done high the cycle after E0; busy never asserts; no tick is needed.
- Back-to-back: start may be accepted in the IDLE cycle immediately after the DONE cycle.
- A tick pulse held longer than one cycle counts once per high cycle. The block relies on the divider to supply single-cycle pulses.
- Reset asserted mid-playback: all outputs go to their reset values immediately, with no clock required. seed_reg also returns to LFSR_SEED.

## Test plan
- Reset, then start with length=2 and default seed, then 5 ticks spaced 10 cycles apart → led sequence:
  - Tick 1: 0010 (lfsr 16'hACE1, color 1).
  - Tick 2: 0000.
  - Tick 3: 1000 (lfsr 16'h59C3, color 3).
  - Tick 4: 0000.
  - Tick 5: done pulses one cycle after the edge; busy falls at the same edge.
- seed_load with seed=0 in IDLE, then start with length=1 → plays from 16'hACE1: led=0010 on tick 1, done after tick 3.
- start with length=0 → done=1 exactly one cycle later; led stays 0; busy stays 0.
- start with length=31 and MAX_LEN=16 → exactly 16 lit steps; done after tick 33.
- start and tick in the same cycle, and start or seed_load issued while busy:
  - The coincident tick is ignored; the first LED lights on the next tick.
  - The extra start is ignored; the sequence and step count are unchanged.
  - seed_reg is unchanged; the next round replays the old seed.
- reset asserted during SHOW with led=0010 → led=0, busy=0, done=0 asynchronously; a later start replays from 16'hACE1.
